branch_tag_tracker: RTL and testbench
=====================================

Name: branch_tag_tracker

Overview:
- Parametrised successor to the single-branch resolution FSM.
- Tracks up to MAX_BRANCHES unresolved branches at once instead of stalling fetch on the second branch.
- Sits between decode/dispatch, which allocates a tag per branch, and the branch execution unit, which resolves tags.
- Emits registered kill/resolve pulses plus slot masks so the ROB, RS and map-table snapshot logic can squash or release per-branch state.

Parameters:
- MAX_BRANCHES, 4, number of concurrently tracked branches (power of two, 2..16).
- TAG_W, $clog2(MAX_BRANCHES), width of a branch tag (slot index).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- branch_detected  input  1  dispatch requests a new branch tag this cycle.
- alloc_ok  output  1  combinational; branch_detected accepted this cycle.
- alloc_tag  output  TAG_W  combinational; tag granted, valid when alloc_ok.
- valid_in  input  1  resolution request from the branch unit.
- resolve_tag  input  TAG_W  tag being resolved.
- take_branch  input  1  branch taken; speculation is always not-taken, so 1 means mispredict.
- busy  output  1  all slots active; dispatch must stall branches.
- active_mask  output  MAX_BRANCHES  registered; bit i set while slot i is allocated.
- kill  output  1  registered one-cycle pulse: mispredict squash.
- resolve  output  1  registered one-cycle pulse: correct prediction confirmed.
- kill_mask  output  MAX_BRANCHES  registered; slots squashed (resolved branch plus all younger). Zero when kill=0.
- resolve_mask  output  MAX_BRANCHES  registered; one-hot resolved slot. Zero when resolve=0.

Behaviour:
- State: active_mask, plus per-slot dependency vector dep[i] (MAX_BRANCHES bits) = active_mask captured when slot i was allocated, i.e. the older branches.
- Reset: active_mask=0, all dep=0, kill=0, resolve=0, kill_mask=0, resolve_mask=0. Asynchronous; an in-flight resolution is discarded.
- Allocation:
  - alloc_ok = branch_detected & ~busy & ~squash_now, where squash_now = valid_in & take_branch & active[resolve_tag].
  - alloc_tag = lowest-index free slot.
  - On the clock edge: active[alloc_tag] <= 1; dep[alloc_tag] <= active_mask minus any slot freed this cycle.
- Resolution is accepted only if valid_in & active[resolve_tag]. A request for an inactive tag is ignored: no pulse, no state change.
- Correct prediction (take_branch=0):
  - Next cycle: resolve=1, resolve_mask=onehot(resolve_tag).
  - Slot cleared.
  - Bit resolve_tag cleared in every dep[j].
- Mispredict (take_branch=1):
  - Squash set S = {resolve_tag} ∪ {j : active[j] & dep[j][resolve_tag]}.
  - Next cycle: kill=1, kill_mask=S.
  - All slots in S cleared; their dep vectors zeroed.
- Latency: every pulse appears exactly 1 cycle after the accepting edge and lasts 1 cycle. Masks are valid only in the pulse cycle.
- Simultaneous events:
  - Allocate + correct resolve in the same cycle: both take effect. The freed slot is not reusable in that cycle (busy/alloc_tag come from current state).
  - Allocate + mispredict in the same cycle: allocation refused (alloc_ok=0), because the new branch is on the wrong path.
- Full: busy=1 when active_mask is all ones. alloc_ok=0 regardless of branch_detected.
- Empty: active_mask=0. Every resolution request is ignored.
- One resolution per cycle.

Test Plan:
- Reset, then branch_detected 3 consecutive cycles -> alloc_tag 0,1,2; active_mask=4'b0111; busy=0.
- Fill 4 slots; branch_detected again -> alloc_ok=0, busy=1. Resolve tag 2, take_branch=0 -> next cycle resolve=1, resolve_mask=4'b0100, active_mask=4'b1011; next allocation returns tag 2.
- Slots 0..3 allocated in order; mispredict tag 1 -> next cycle kill=1, kill_mask=4'b1110, active_mask=4'b0001.
- Same cycle: branch_detected plus mispredict tag 0 with 2 slots active -> alloc_ok=0, kill_mask=4'b0011, active_mask=0.
- Resolve inactive tag 3 with valid_in=1 -> kill=0, resolve=0, masks unchanged.
- Assert reset with 3 slots active and a resolution in flight -> active_mask=0, kill=0, resolve=0 immediately. First post-reset allocation returns tag 0.

Source files
------------

// File: rtl/branch_tag_tracker.sv
// rtl/branch_tag_tracker.sv - multi-branch tag allocator with kill/resolve pulses and slot masks
module branch_tag_tracker #(
  parameter int MAX_BRANCHES = 4,
  parameter int TAG_W        = $clog2(MAX_BRANCHES)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    branch_detected,
  output logic                    alloc_ok,
  output logic [TAG_W-1:0]        alloc_tag,
  input  logic                    valid_in,
  input  logic [TAG_W-1:0]        resolve_tag,
  input  logic                    take_branch,
  output logic                    busy,
  output logic [MAX_BRANCHES-1:0] active_mask,
  output logic                    kill,
  output logic                    resolve,
  output logic [MAX_BRANCHES-1:0] kill_mask,
  output logic [MAX_BRANCHES-1:0] resolve_mask
);

  // dep[i] holds the set of branches that were older than slot i when it was allocated
  logic [MAX_BRANCHES-1:0] dep [MAX_BRANCHES];

  logic                    res_hit;
  logic                    squash_now;
  logic [MAX_BRANCHES-1:0] tag_onehot;
  logic [MAX_BRANCHES-1:0] squash_set;
  logic [MAX_BRANCHES-1:0] freed;
  logic [MAX_BRANCHES-1:0] alloc_onehot;

  assign busy       = &active_mask;
  assign res_hit    = valid_in & active_mask[resolve_tag];
  assign squash_now = res_hit & take_branch;
  assign alloc_ok   = branch_detected & ~busy & ~squash_now;
  assign tag_onehot = MAX_BRANCHES'(1) << resolve_tag;

  // Lowest-index free slot; scanning downward leaves the smallest index as the winner
  always_comb begin
    alloc_tag = '0;
    for (int i = MAX_BRANCHES - 1; i >= 0; i--) begin
      if (!active_mask[i]) alloc_tag = TAG_W'(i);
    end
  end

  // Mispredict squash set: the resolved branch plus every live branch that depends on it
  always_comb begin
    squash_set = tag_onehot;
    for (int j = 0; j < MAX_BRANCHES; j++) begin
      if (active_mask[j] && dep[j][resolve_tag]) squash_set[j] = 1'b1;
    end
  end

  // Slots released this cycle, and the slot being granted (never granted during a squash)
  always_comb begin
    freed = '0;
    if (res_hit) freed = take_branch ? squash_set : tag_onehot;
    alloc_onehot = alloc_ok ? (MAX_BRANCHES'(1) << alloc_tag) : '0;
  end

  // Slot state, dependency vectors and the registered one-cycle result pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_mask  <= '0;
      kill         <= 1'b0;
      resolve      <= 1'b0;
      kill_mask    <= '0;
      resolve_mask <= '0;
      for (int i = 0; i < MAX_BRANCHES; i++) dep[i] <= '0;
    end else begin
      active_mask  <= (active_mask & ~freed) | alloc_onehot;
      kill         <= squash_now;
      resolve      <= res_hit & ~take_branch;
      kill_mask    <= squash_now ? squash_set : '0;
      resolve_mask <= (res_hit && !take_branch) ? tag_onehot : '0;
      for (int i = 0; i < MAX_BRANCHES; i++) begin
        if (alloc_onehot[i])
          // A slot freed this same cycle is no longer older than the new branch
          dep[i] <= active_mask & ~freed;
        else if (freed[i])
          dep[i] <= '0;
        else
          dep[i] <= dep[i] & ~freed;
      end
    end
  end

endmodule

// File: tb/tb_branch_tag_tracker.sv
// tb/tb_branch_tag_tracker.sv - scoreboard bench for branch_tag_tracker
module tb_branch_tag_tracker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       branch_detected = 1'b0;
  logic       alloc_ok;
  logic [1:0] alloc_tag;
  logic       valid_in = 1'b0;
  logic [1:0] resolve_tag = 2'd0;
  logic       take_branch = 1'b0;
  logic       busy;
  logic [3:0] active_mask;
  logic       kill;
  logic       resolve;
  logic [3:0] kill_mask;
  logic [3:0] resolve_mask;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {kill, resolve, kill_mask, resolve_mask, active_mask}
  logic [13:0] sb [$];
  logic [13:0] exp_v;

  branch_tag_tracker #(.MAX_BRANCHES(4)) dut (
    .clock(clock), .reset(reset), .branch_detected(branch_detected),
    .alloc_ok(alloc_ok), .alloc_tag(alloc_tag), .valid_in(valid_in),
    .resolve_tag(resolve_tag), .take_branch(take_branch), .busy(busy),
    .active_mask(active_mask), .kill(kill), .resolve(resolve),
    .kill_mask(kill_mask), .resolve_mask(resolve_mask)
  );

  always #5 clock = ~clock;

  function automatic logic [13:0] obs();
    return {kill, resolve, kill_mask, resolve_mask, active_mask};
  endfunction

  function automatic logic [13:0] mk(logic k, logic r, logic [3:0] km, logic [3:0] rm, logic [3:0] am);
    return {k, r, km, rm, am};
  endfunction

  task automatic clk_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    branch_detected = 1'b0;
    valid_in        = 1'b0;
    take_branch     = 1'b0;
    resolve_tag     = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    clk_edge();
    reset = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      branch_detected = 1'b1;
      clk_edge();
    end
    branch_detected = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    sb.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000));
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", obs(), exp_v);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_alloc();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      branch_detected = 1'b1;
      #1;
      n_checks++;
      if ({alloc_ok, alloc_tag} !== {1'b1, 2'(i)}) begin
        n_fail++;
        $display("FAIL alloc_seq_%0d: got ok=%b tag=%0d want ok=1 tag=%0d", i, alloc_ok, alloc_tag, i);
      end
      sb.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'((1 << (i + 1)) - 1)));
      clk_edge();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL alloc_state_%0d: got %b want %b", i, obs(), exp_v);
      end
    end
    branch_detected = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_full_resolve();
    do_reset();
    alloc_n(4);
    branch_detected = 1'b1;
    #1;
    n_checks++;
    if ({busy, alloc_ok} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_refuse: got busy=%b ok=%b want busy=1 ok=0", busy, alloc_ok);
    end
    branch_detected = 1'b0;
    valid_in = 1'b1; resolve_tag = 2'd2; take_branch = 1'b0;
    sb.push_back(mk(0, 1, 4'b0000, 4'b0100, 4'b1011));
    clk_edge();
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL full_resolve: got %b want %b", obs(), exp_v);
    end
    idle_inputs();
    branch_detected = 1'b1;
    #1;
    n_checks++;
    if ({alloc_ok, alloc_tag} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL full_realloc: got ok=%b tag=%0d want ok=1 tag=2", alloc_ok, alloc_tag);
    end
    sb.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1111));
    clk_edge();
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL full_pulse_end: got %b want %b", obs(), exp_v);
    end
    branch_detected = 1'b0;
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc_n(4);
    valid_in = 1'b1; resolve_tag = 2'd1; take_branch = 1'b1;
    sb.push_back(mk(1, 0, 4'b1110, 4'b0000, 4'b0001));
    clk_edge();
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL mispredict_kill: got %b want %b", obs(), exp_v);
    end
    idle_inputs();
    sb.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0001));
    clk_edge();
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL mispredict_pulse_end: got %b want %b", obs(), exp_v);
    end
  endtask

  task automatic test_alloc_with_mispredict();
    do_reset();
    alloc_n(2);
    branch_detected = 1'b1;
    valid_in = 1'b1; resolve_tag = 2'd0; take_branch = 1'b1;
    #1;
    n_checks++;
    if (alloc_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_mispredict_ok: got %b want 0", alloc_ok);
    end
    sb.push_back(mk(1, 0, 4'b0011, 4'b0000, 4'b0000));
    clk_edge();
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL alloc_mispredict_kill: got %b want %b", obs(), exp_v);
    end
    idle_inputs();
  endtask

  task automatic test_inactive();
    do_reset();
    alloc_n(3);
    for (int t = 0; t < 2; t++) begin
      valid_in = 1'b1; resolve_tag = 2'd3; take_branch = 1'(t);
      sb.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0111));
      clk_edge();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL inactive_take%0d: got %b want %b", t, obs(), exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_n(2);
    // allocate and correctly resolve slot 0 together: slot 0 not reusable yet
    branch_detected = 1'b1;
    valid_in = 1'b1; resolve_tag = 2'd0; take_branch = 1'b0;
    #1;
    n_checks++;
    if ({alloc_ok, alloc_tag} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL b2b_alloc_tag: got ok=%b tag=%0d want ok=1 tag=2", alloc_ok, alloc_tag);
    end
    sb.push_back(mk(0, 1, 4'b0000, 4'b0001, 4'b0110));
    clk_edge();
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_resolve: got %b want %b", obs(), exp_v);
    end
    // reuse slot 0; it is younger than slots 1 and 2
    valid_in = 1'b0;
    #1;
    n_checks++;
    if ({alloc_ok, alloc_tag} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL b2b_reuse_tag: got ok=%b tag=%0d want ok=1 tag=0", alloc_ok, alloc_tag);
    end
    sb.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0111));
    clk_edge();
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_reuse_state: got %b want %b", obs(), exp_v);
    end
    // squash new slot 0: slot 2 must survive (it no longer depends on slot 0)
    branch_detected = 1'b0;
    valid_in = 1'b1; resolve_tag = 2'd0; take_branch = 1'b1;
    sb.push_back(mk(1, 0, 4'b0001, 4'b0000, 4'b0110));
    clk_edge();
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_kill_young: got %b want %b", obs(), exp_v);
    end
    // squash slot 1 immediately after: slot 2 depends on it
    resolve_tag = 2'd1;
    sb.push_back(mk(1, 0, 4'b0110, 4'b0000, 4'b0000));
    clk_edge();
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_kill_chain: got %b want %b", obs(), exp_v);
    end
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    alloc_n(3);
    valid_in = 1'b1; resolve_tag = 2'd1; take_branch = 1'b0;
    clk_edge();
    valid_in = 1'b1; resolve_tag = 2'd0; take_branch = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    sb.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000));
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_async: got %b want %b", obs(), exp_v);
    end
    clk_edge();
    idle_inputs();
    reset = 1'b0;
    branch_detected = 1'b1;
    #1;
    n_checks++;
    if ({alloc_ok, alloc_tag} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_first_alloc: got ok=%b tag=%0d want ok=1 tag=0", alloc_ok, alloc_tag);
    end
    sb.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0001));
    clk_edge();
    exp_v = sb.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_first_state: got %b want %b", obs(), exp_v);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_full_resolve();
    test_mispredict();
    test_alloc_with_mispredict();
    test_inactive();
    test_back_to_back();
    test_reset_inflight();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
